operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have no parameters; widths are fixed: XLEN 32, register index 5.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid / in_ready / in_instr  in / out / in  1 / 1 / 32  instruction handshake from decode.
REQ-005 wb_valid / wb_ready / wb_rd / wb_data  in / out / in / in  1 / 1 / 5 / 32  writeback request.
REQ-006 rf_read / rf_write / rf_regno / rf_wdata  out  1 / 1 / 5 / 32  register-file port (RegRead, RegWrite, regno, wdata).
REQ-007 rf_rdata  in  32  register-file read data, valid the cycle after rf_read was high.
REQ-008 out_valid / out_ready / out_instr / out_rs1 / out_rs2  out / in / out / out / out  1 / 1 / 32 / 32 / 32  operand bundle to execute.

Function
REQ-009 The block SHALL decode rs1 = instr[19:15] and rs2 = instr[24:20] from the accepted instruction.
REQ-010 The FSM SHALL have states IDLE, RS1, RS2, DRAIN, OUT; in_ready SHALL be 1 only in IDLE.
REQ-011 IDLE->RS1 on in_valid&in_ready (instruction latched); RS1->RS2 and RS2->DRAIN on a cycle in which the read is issued; DRAIN->OUT unconditionally; OUT->IDLE on out_ready.
REQ-012 In RS1/RS2, rf_read SHALL be 1 with rf_regno = rs1/rs2, unless a write is issued that cycle, in which case the state holds.
REQ-013 rf_read and rf_write SHALL never both be 1 in the same cycle.
REQ-014 A read issued in cycle N SHALL be captured from rf_rdata at the end of cycle N+1 into its slot, via a pending flag plus slot tag, independent of state.
REQ-015 Writeback SHALL have priority: wb_ready = 1 in every state; when wb_valid=1 and wb_rd != 0, rf_write=1, rf_regno=wb_rd, rf_wdata=wb_data.
REQ-016 A writeback to x0 SHALL be accepted (wb_ready=1) with rf_write=0.
REQ-017 A source index of 0 SHALL yield operand 0 regardless of rf_rdata; the read is still issued.
REQ-018 out_valid SHALL be 1 only in OUT; out_* SHALL be stable while out_valid & !out_ready.
REQ-019 Best-case latency SHALL be 4 cycles: accept at edge E0, out_valid high after edge E3.
REQ-020 Outputs with no valid qualifier (out_rs1, out_rs2, out_instr, rf_regno, rf_wdata) SHALL drive the last captured or held value, never X.

Reset
REQ-021 On rst: state=IDLE, pending=0; out_valid, rf_read, rf_write = 0; in_ready = 1; operand, instruction and regno registers = 0.
REQ-022 Reset mid-operation SHALL abandon the instruction; a capture pending at the reset edge SHALL be discarded.

Configuration
REQ-023 With OPFETCH_FWD_EN defined: an accepted writeback to rd != 0 that matches a slot whose read was already issued SHALL overwrite that slot with wb_data at the same edge, overriding a simultaneous capture.
REQ-024 Without OPFETCH_FWD_EN: slots SHALL change only by capture; hazard stalling is owned upstream.

Structure
REQ-025 A shared package rv32_pkg SHALL hold XLEN, REG_IDX_W, the opfetch_state_e enum and the rs1/rs2 field-position constants.
REQ-026 One sub-module, opfetch_fsm (state register, next-state logic, pending tag), is natural; the capture/forward datapath stays in operand_fetch.

Verification
REQ-027 Preload x5=0x11, x6=0x22; instr rs1=5 rs2=6, out_ready=1, no wb -> out_valid 4 cycles after accept with out_rs1=0x11, out_rs2=0x22.
REQ-028 wb_valid (rd=9, data=0xAB) held high throughout RS1 -> RS1 stalls 1 cycle per wb beat; x9 written; no cycle with rf_read&rf_write.
REQ-029 instr rs1=0 rs2=0 with x0 cells poisoned to 0xFFFF_FFFF -> out_rs1 = out_rs2 = 0.
REQ-030 OPFETCH_FWD_EN: rs1=7 (old 0x1), wb rd=7 data=0x77 during DRAIN -> out_rs1=0x77; same case without the macro -> 0x1.
REQ-031 out_ready=0 for 5 cycles in OUT -> out_* stable, in_ready=0; rst pulsed during RS2 -> next cycle IDLE, in_ready=1, out_valid=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 constants and operand-fetch FSM encoding.
package rv32_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RS1   = 3'd1,
        ST_RS2   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } opfetch_state_e;

    function automatic logic [REG_IDX_W-1:0] rs_field(input logic [XLEN-1:0] instr,
                                                      input int lsb);
        return instr[lsb +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/opfetch_fsm.sv
// Operand-fetch sequencer: state register, next-state logic and the
// pending-read tag that tells the datapath which slot to capture next cycle.
module opfetch_fsm
    import rv32_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic           out_ready,
    input  logic           wr_issue,
    output opfetch_state_e state,
    output logic           in_ready,
    output logic           out_valid,
    output logic           accept,
    output logic           rd_issue,
    output logic           pend,
    output logic           pend_slot
);

    opfetch_state_e state_d;
    logic           rd_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend      <= 1'b0;
            pend_slot <= 1'b0;
        end else begin
            state <= state_d;
            pend  <= rd_issue;
            if (rd_issue)
                pend_slot <= rd_slot;
        end
    end

    // A writeback owns the register-file port, so a read state holds until free.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (in_valid)  state_d = ST_RS1;
            ST_RS1:   if (!wr_issue) state_d = ST_RS2;
            ST_RS2:   if (!wr_issue) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT:   if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_OUT);
        accept    = in_ready && in_valid;
        rd_issue  = ((state == ST_RS1) || (state == ST_RS2)) && !wr_issue;
        rd_slot   = (state == ST_RS2);
    end

endmodule

// File: rtl/operand_fetch.sv
// Fetches rs1/rs2 operands through a single shared register-file port.
// Optional OPFETCH_FWD_EN: writebacks overwrite already-read operand slots.
module operand_fetch
    import rv32_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_instr,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 rf_read,
    output logic                 rf_write,
    output logic [REG_IDX_W-1:0] rf_regno,
    output logic [XLEN-1:0]      rf_wdata,
    input  logic [XLEN-1:0]      rf_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_instr,
    output logic [XLEN-1:0]      out_rs1,
    output logic [XLEN-1:0]      out_rs2
);

    opfetch_state_e        state;
    logic                  accept, rd_issue, pend, pend_slot, wr_issue;
    logic [XLEN-1:0]       instr_q, op1_q, op2_q, wdata_q;
    logic [REG_IDX_W-1:0]  regno_q, rs1_idx, rs2_idx;

    // Writes to x0 are swallowed here so they never cost a read slot.
    assign wr_issue = !rst && wb_valid && (wb_rd != '0);
    assign wb_ready = 1'b1;

    assign rs1_idx = rs_field(instr_q, RS1_LSB);
    assign rs2_idx = rs_field(instr_q, RS2_LSB);

    opfetch_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .wr_issue  (wr_issue),
        .state     (state),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .accept    (accept),
        .rd_issue  (rd_issue),
        .pend      (pend),
        .pend_slot (pend_slot)
    );

    always_comb begin
        rf_read  = rd_issue;
        rf_write = wr_issue;
        rf_wdata = wr_issue ? wb_data : wdata_q;
        if (wr_issue)
            rf_regno = wb_rd;
        else if (rd_issue)
            rf_regno = (state == ST_RS2) ? rs2_idx : rs1_idx;
        else
            rf_regno = regno_q;
    end

`ifdef OPFETCH_FWD_EN
    logic iss1_q, iss2_q, fwd_live;

    // Forward only while the bundle is still being assembled; OUT must stay stable.
    assign fwd_live = wr_issue &&
                      ((state == ST_RS1) || (state == ST_RS2) || (state == ST_DRAIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss1_q <= 1'b0;
            iss2_q <= 1'b0;
        end else if (accept) begin
            iss1_q <= 1'b0;
            iss2_q <= 1'b0;
        end else if (rd_issue) begin
            if (state == ST_RS2) iss2_q <= 1'b1;
            else                 iss1_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            regno_q <= '0;
            wdata_q <= '0;
        end else begin
            if (accept)
                instr_q <= in_instr;
            if (rf_read || rf_write)
                regno_q <= rf_regno;
            if (wr_issue)
                wdata_q <= wb_data;
            if (pend) begin
                if (!pend_slot) op1_q <= (rs1_idx == '0) ? '0 : rf_rdata;
                else            op2_q <= (rs2_idx == '0) ? '0 : rf_rdata;
            end
`ifdef OPFETCH_FWD_EN
            // Later assignment wins over a same-edge capture of stale data.
            if (fwd_live && iss1_q && (rs1_idx == wb_rd)) op1_q <= wb_data;
            if (fwd_live && iss2_q && (rs2_idx == wb_rd)) op2_q <= wb_data;
`endif
        end
    end

    assign out_instr = instr_q;
    assign out_rs1   = op1_q;
    assign out_rs2   = op2_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model, vector table, scoreboard and
// hand-written writeback / forwarding / stall / reset sequences.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, wb_valid, wb_ready;
    logic [31:0] in_instr, wb_data, rf_wdata, out_instr, out_rs1, out_rs2;
    logic [4:0]  wb_rd, rf_regno;
    logic        rf_read, rf_write, out_valid, out_ready;
    logic [31:0] rf_rdata = '0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_read(rf_read), .rf_write(rf_write), .rf_regno(rf_regno),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_rs1(out_rs1), .out_rs2(out_rs2)
    );

    // Register-file model: x0 is an ordinary cell so it can be poisoned.
    logic [31:0] mem [32];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en)   mem[pre_idx] <= pre_data;
        if (rf_write) mem[rf_regno] <= rf_wdata;
        if (rf_read)  rf_rdata <= mem[rf_regno];
    end

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (rf_read && rf_write) overlap++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_instr", out_instr, e.instr);
                chk("sb_rs1", out_rs1, e.r1);
                chk("sb_rs2", out_rs2, e.r2);
            end
        end
    end

    task automatic issue(input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input bit push, output logic [31:0] ins);
        int n;
        ins = {7'h00, s2, s1, 3'b000, 5'($urandom_range(1, 31)), 7'h33};
        if (push) sb.push_back('{ins, e1, e2});
        in_instr = ins;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        c = 0;
        while (!out_valid && c < 30) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    endtask

    typedef struct {
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] val;
    } pre_t;

    initial begin
        vec_t        tbl[6];
        pre_t        pre[8];
        logic [31:0] ins, fwd1, fwd5;
        int          c;

        tbl[0] = '{5'd5,  5'd6,  32'h11,        32'h22};
        tbl[1] = '{5'd0,  5'd0,  32'h0,         32'h0};
        tbl[2] = '{5'd31, 5'd10, 32'hDEADBEEF,  32'h1234};
        tbl[3] = '{5'd11, 5'd0,  32'hCAFEF00D,  32'h0};
        tbl[4] = '{5'd6,  5'd6,  32'h22,        32'h22};
        tbl[5] = '{5'd0,  5'd11, 32'h0,         32'hCAFEF00D};

        pre[0] = '{5'd0,  32'hFFFFFFFF};
        pre[1] = '{5'd5,  32'h11};
        pre[2] = '{5'd6,  32'h22};
        pre[3] = '{5'd7,  32'h1};
        pre[4] = '{5'd10, 32'h1234};
        pre[5] = '{5'd11, 32'hCAFEF00D};
        pre[6] = '{5'd31, 32'hDEADBEEF};
        pre[7] = '{5'd9,  32'h0};

        in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

        // Preload the RF model while the DUT is held in reset.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 pre_en = 1'b1; pre_idx = pre[i].idx; pre_data = pre[i].val;
        end
        @(posedge clk);
        #1 pre_en = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h3333;

        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rf_read", {31'd0, rf_read}, 32'd0);
        chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
        chk("rst_out_rs1", out_rs1, 32'd0);
        chk("rst_out_rs2", out_rs2, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_rf_regno", {27'd0, rf_regno}, 32'd0);
        wb_valid = 1'b0;
        rst = 1'b0;

        // Writeback to x0 is accepted but never reaches the RF.
        @(posedge clk);
        #1 wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h5555;
        @(negedge clk);
        chk("x0_wb_ready", {31'd0, wb_ready}, 32'd1);
        chk("x0_wb_no_write", {31'd0, rf_write}, 32'd0);
        @(posedge clk);
        #1 wb_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].s1, tbl[i].s2, tbl[i].e1, tbl[i].e2, 1'b1, ins);
            wait_out(c);
            chk("latency", c, 32'd3);
            @(posedge clk);
            #1;
        end

        // Writeback held across RS1: each beat steals the RF port for a cycle.
        issue(5'd5, 5'd6, 32'h11, 32'h22, 1'b1, ins);
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hAB;
        @(negedge clk);
        chk("wb_rf_write", {31'd0, rf_write}, 32'd1);
        chk("wb_rf_read_blocked", {31'd0, rf_read}, 32'd0);
        chk("wb_rf_regno", {27'd0, rf_regno}, 32'd9);
        chk("wb_rf_wdata", rf_wdata, 32'hAB);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wb_stall2_read_blocked", {31'd0, rf_read}, 32'd0);
        @(posedge clk);
        #1 wb_valid = 1'b0;
        wait_out(c);
        chk("wb_latency", c + 2, 32'd5);
        @(posedge clk);
        #1;
        chk("no_rd_wr_overlap", overlap, 32'd0);
        issue(5'd9, 5'd0, 32'hAB, 32'h0, 1'b1, ins);
        wait_out(c);
        @(posedge clk);
        #1;

`ifdef OPFETCH_FWD_EN
        fwd1 = 32'h77;
        fwd5 = 32'h55;
`else
        fwd1 = 32'h1;
        fwd5 = 32'h11;
`endif
        // Writeback to rs1 during DRAIN, after its read was issued.
        issue(5'd7, 5'd6, fwd1, 32'h22, 1'b1, ins);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
        @(posedge clk);
        #1 wb_valid = 1'b0;
        wait_out(c);
        chk("fwd_drain_latency", c, 32'd0);
        @(posedge clk);
        #1;

        // Writeback to rs1 on the edge its stale read data is captured.
        issue(5'd5, 5'd6, fwd5, 32'h22, 1'b1, ins);
        @(posedge clk);
        #1 wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
        @(posedge clk);
        #1 wb_valid = 1'b0;
        wait_out(c);
        @(posedge clk);
        #1;

        // Backpressure in OUT: bundle must hold for 5 cycles.
        out_ready = 1'b0;
        issue(5'd10, 5'd31, 32'h1234, 32'hDEADBEEF, 1'b1, ins);
        wait_out(c);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_out_rs1", out_rs1, 32'h1234);
            chk("hold_out_rs2", out_rs2, 32'hDEADBEEF);
            chk("hold_out_instr", out_instr, ins);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release_idle", {31'd0, in_ready}, 32'd1);

        // Reset during RS2 with an rs1 capture pending.
        issue(5'd5, 5'd6, 32'h0, 32'h0, 1'b0, ins);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_rf_read", {31'd0, rf_read}, 32'd0);
        chk("midrst_out_instr", out_instr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_pend_dropped", out_rs1, 32'd0);
        chk("midrst_idle", {31'd0, in_ready}, 32'd1);
        chk("midrst_no_out", {31'd0, out_valid}, 32'd0);

        issue(5'd6, 5'd10, 32'h22, 32'h1234, 1'b1, ins);
        wait_out(c);
        chk("post_rst_latency", c, 32'd3);
        @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
